// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon-128 sequencing controller.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    FIN,
    END
  } type_ctrl_state;

  typedef logic [3:0] type_round;

  localparam int        ROUNDS_A      = 12;
  localparam type_round ROUND_B_START = 4'd6;
  localparam type_round ROUND_LAST    = 4'(ROUNDS_A - 1);

  // WAIT states are the only ones that talk to the top-level data handshake.
  function automatic logic is_wait(type_ctrl_state s);
    return (s == WAIT_AD) || (s == WAIT_PT);
  endfunction

endpackage

// File: rtl/ascon_fsm_ctrl_if.sv
// Top-level handshake between the message source/sink and the controller.
interface ascon_fsm_ctrl_if;
  logic start_i;
  logic data_valid_i;
  logic data_ready_o;
  logic cipher_valid_o;
  logic tag_valid_o;
  logic done_o;

  modport master (
    output start_i, data_valid_i,
    input  data_ready_o, cipher_valid_o, tag_valid_o, done_o
  );

  modport slave (
    input  start_i, data_valid_i,
    output data_ready_o, cipher_valid_o, tag_valid_o, done_o
  );
endinterface

// File: rtl/ascon_round_counter.sv
// Loadable round index counter; wraps 11 -> 0 so it never leaves 0..11.
module ascon_round_counter
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      load_i,
  input  type_round load_value_i,
  input  logic      en_i,
  output type_round round_o,
  output logic      last_o
);

  type_round cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)       cnt_d = load_value_i;
    else if (en_i)    cnt_d = (cnt_q == ROUND_LAST) ? 4'd0 : cnt_q + 4'd1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) cnt_q <= 4'd0;
    else         cnt_q <= cnt_d;
  end

  assign round_o = cnt_q;
  assign last_o  = (cnt_q == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// Ascon-128 AEAD sequencer: walks INIT/AD/PT/FIN and drives the
// permutation datapath control lines one round per clock.
module ascon_fsm_ctrl
  import ascon_pack::*;
#(
  parameter int NB_AD = 1,
  parameter int NB_PT = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  ascon_fsm_ctrl_if.slave   bus,
  output logic              selectionp_o,
  output logic              enable_o,
  output logic              bypass_begin_o,
  output logic              bypass_end_o,
  output logic              mode_int_ext_o,
  output logic              mode_init_data_o,
  output type_round         round_o
);

  type_ctrl_state state_q, state_d;
  logic [3:0]     ad_cnt_q, ad_cnt_d;
  logic [3:0]     pt_cnt_q, pt_cnt_d;
  logic           tag_q, tag_d;

  logic      cnt_load, cnt_en, rnd_last;
  type_round cnt_val, rnd;

  logic ad_last, pt_last, accept;

  ascon_round_counter u_round (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_i       (cnt_load),
    .load_value_i (cnt_val),
    .en_i         (cnt_en),
    .round_o      (rnd),
    .last_o       (rnd_last)
  );

  assign ad_last = (ad_cnt_q == 4'(NB_AD - 1));
  assign pt_last = (pt_cnt_q == 4'(NB_PT - 1));
  assign accept  = is_wait(state_q) && bus.data_valid_i;

  always_comb begin
    state_d  = state_q;
    ad_cnt_d = ad_cnt_q;
    pt_cnt_d = pt_cnt_q;
    cnt_load = 1'b0;
    cnt_val  = 4'd0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE, END: begin
        if (bus.start_i) begin
          state_d  = INIT;
          cnt_load = 1'b1;
          ad_cnt_d = 4'd0;
          pt_cnt_d = 4'd0;
        end
      end
      INIT: begin
        if (rnd_last) begin
          state_d  = WAIT_AD;
          cnt_load = 1'b1;
          cnt_val  = ROUND_B_START;
        end else cnt_en = 1'b1;
      end
      WAIT_AD: begin
        // The accepting cycle already executes round 6.
        if (bus.data_valid_i) begin
          state_d = AD;
          cnt_en  = 1'b1;
        end
      end
      AD: begin
        if (rnd_last) begin
          ad_cnt_d = ad_cnt_q + 4'd1;
          cnt_load = 1'b1;
          cnt_val  = ROUND_B_START;
          state_d  = ad_last ? WAIT_PT : WAIT_AD;
        end else cnt_en = 1'b1;
      end
      WAIT_PT: begin
        if (bus.data_valid_i) begin
          pt_cnt_d = pt_cnt_q + 4'd1;
          if (pt_last) begin
            state_d  = FIN;
            cnt_load = 1'b1;
          end else begin
            state_d = PT;
            cnt_en  = 1'b1;
          end
        end
      end
      PT: begin
        if (rnd_last) begin
          state_d  = WAIT_PT;
          cnt_load = 1'b1;
          cnt_val  = ROUND_B_START;
        end else cnt_en = 1'b1;
      end
      FIN: begin
        if (rnd_last) begin
          state_d  = END;
          cnt_load = 1'b1;
        end else cnt_en = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    tag_d = (state_d == END) && (state_q != END);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ad_cnt_q <= 4'd0;
      pt_cnt_q <= 4'd0;
      tag_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ad_cnt_q <= ad_cnt_d;
      pt_cnt_q <= pt_cnt_d;
      tag_q    <= tag_d;
    end
  end

  // Decode from registered state; only the WAIT-state accept path sees data_valid_i.
  always_comb begin
    enable_o         = 1'b0;
    bypass_begin_o   = 1'b1;
    bypass_end_o     = 1'b1;
    mode_int_ext_o   = 1'b0;
    mode_init_data_o = 1'b0;
    selectionp_o     = !((state_q == IDLE) || ((state_q == INIT) && (rnd == 4'd0)));
    case (state_q)
      INIT: begin
        enable_o     = 1'b1;
        bypass_end_o = !rnd_last;
      end
      WAIT_AD, WAIT_PT: begin
        if (bus.data_valid_i) begin
          enable_o       = 1'b1;
          bypass_begin_o = 1'b0;
        end
      end
      AD: begin
        enable_o = 1'b1;
        if (rnd_last && ad_last) begin
          bypass_end_o     = 1'b0;
          mode_init_data_o = 1'b1;
        end
      end
      PT: enable_o = 1'b1;
      FIN: begin
        enable_o = 1'b1;
        if (rnd == 4'd0) begin
          bypass_begin_o = 1'b0;
          mode_int_ext_o = 1'b1;
        end
        bypass_end_o = !rnd_last;
      end
      default: ;
    endcase
  end

  assign round_o            = rnd;
  assign bus.data_ready_o   = is_wait(state_q);
  assign bus.cipher_valid_o = accept && (state_q == WAIT_PT);
  assign bus.tag_valid_o    = tag_q;
  assign bus.done_o         = (state_q == END);

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Self-checking bench: per-cycle expected-output schedule built from the
// message flow rules (block counts, stalls), plus latency/ciphertext checks.
module tb_ascon_fsm_ctrl;
  localparam int NB_AD = 1;
  localparam int NB_PT = 4;
  localparam int BASE_LAT = 12 + 6*NB_AD + 6*(NB_PT-1) + 1 + 12 + 1;

  logic clk = 1'b0;
  logic rst;
  logic sel, en, bb, be, mie, mid;
  logic [3:0] rnd;

  ascon_fsm_ctrl_if bus_if();

  ascon_fsm_ctrl #(.NB_AD(NB_AD), .NB_PT(NB_PT)) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .bus              (bus_if),
    .selectionp_o     (sel),
    .enable_o         (en),
    .bypass_begin_o   (bb),
    .bypass_end_o     (be),
    .mode_int_ext_o   (mie),
    .mode_init_data_o (mid),
    .round_o          (rnd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        valid;
    logic [13:0] exp;
    logic        eff;
    int          lat;
  } vec_t;

  vec_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   fin_idx;

  function automatic logic [13:0] pk(logic rdy, logic s, logic e, logic b0, logic b1,
                                     logic m0, logic m1, logic [3:0] r,
                                     logic cv, logic tg, logic dn);
    return {rdy, s, e, b0, b1, m0, m1, r, cv, tg, dn};
  endfunction

  logic [13:0] RST_V, END_V, WAIT_V;

  function automatic logic rv();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic rs();
    return ($urandom_range(0, 7) == 0);
  endfunction

  task automatic push(input logic st, input logic v, input logic [13:0] e);
    q.push_back('{rst: 1'b0, start: st, valid: v, exp: e, eff: 1'b0, lat: 0});
  endtask

  task automatic build_msg(input bit from_end, input int st_ad[16], input int st_pt[16],
                           input int n_end);
    int   stalls;
    logic lb;
    stalls = 0;
    for (int b = 0; b < NB_AD; b++) stalls += st_ad[b];
    for (int p = 0; p < NB_PT; p++) stalls += st_pt[p];
    push(1'b1, rv(), from_end ? END_V : RST_V);
    q[q.size()-1].eff = 1'b1;
    q[q.size()-1].lat = BASE_LAT + stalls;
    for (int r = 0; r < 12; r++)
      push(rs(), rv(), pk(0, r != 0, 1, 1, r != 11, 0, 0, 4'(r), 0, 0, 0));
    for (int b = 0; b < NB_AD; b++) begin
      for (int s = 0; s < st_ad[b]; s++) push(rs(), 1'b0, WAIT_V);
      push(rs(), 1'b1, pk(1, 1, 1, 0, 1, 0, 0, 4'd6, 0, 0, 0));
      for (int r = 7; r < 12; r++) begin
        lb = (b == NB_AD-1) && (r == 11);
        push((b == 0 && r == 9) ? 1'b1 : rs(), rv(),
             pk(0, 1, 1, 1, !lb, 0, lb, 4'(r), 0, 0, 0));
      end
    end
    for (int p = 0; p < NB_PT; p++) begin
      for (int s = 0; s < st_pt[p]; s++) push(rs(), 1'b0, WAIT_V);
      push(rs(), 1'b1, pk(1, 1, 1, 0, 1, 0, 0, 4'd6, 1, 0, 0));
      if (p < NB_PT-1)
        for (int r = 7; r < 12; r++)
          push(rs(), rv(), pk(0, 1, 1, 1, 1, 0, 0, 4'(r), 0, 0, 0));
    end
    fin_idx = q.size();
    for (int r = 0; r < 12; r++)
      push(rs(), rv(), pk(0, 1, 1, r != 0, r != 11, r == 0, 0, 4'(r), 0, 0, 0));
    push(1'b0, rv(), pk(0, 1, 0, 1, 1, 0, 0, 4'd0, 0, 1, 1));
    for (int k = 0; k < n_end; k++) push(1'b0, rv(), END_V);
  endtask

  int za[16];
  int sa[16];
  int sp[16];

  task automatic rand_stalls();
    for (int i = 0; i < 16; i++) begin
      sa[i] = $urandom_range(0, 3);
      sp[i] = $urandom_range(0, 3);
    end
  endtask

  task automatic run_queue();
    int          t_start, exp_lat, cv_cnt;
    logic [13:0] got;
    t_start = -1; exp_lat = 0; cv_cnt = 0;
    for (int i = 0; i < q.size(); i++) begin
      rst                 = q[i].rst;
      bus_if.start_i      = q[i].start;
      bus_if.data_valid_i = q[i].valid;
      @(negedge clk);
      got = {bus_if.data_ready_o, sel, en, bb, be, mie, mid, rnd,
             bus_if.cipher_valid_o, bus_if.tag_valid_o, bus_if.done_o};
      checks++;
      if (got !== q[i].exp) begin
        fails++;
        $display("FAIL outputs idx %0d: got rdy,sel,en,bb,be,mie,mid,rnd,cv,tag,done=%b exp %b",
                 i, got, q[i].exp);
      end
      if (q[i].rst) t_start = -1;
      else if (q[i].eff) begin
        t_start = i; exp_lat = q[i].lat; cv_cnt = 0;
      end
      if (t_start >= 0 && bus_if.cipher_valid_o === 1'b1) cv_cnt++;
      if (t_start >= 0 && bus_if.tag_valid_o === 1'b1) begin
        checks++;
        if (i - t_start != exp_lat) begin
          fails++;
          $display("FAIL tag_latency: got %0d exp %0d", i - t_start, exp_lat);
        end
        checks++;
        if (cv_cnt != NB_PT) begin
          fails++;
          $display("FAIL cipher_pulses: got %0d exp %0d", cv_cnt, NB_PT);
        end
        t_start = -1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    RST_V  = pk(0, 0, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0);
    END_V  = pk(0, 1, 0, 1, 1, 0, 0, 4'd0, 0, 0, 1);
    WAIT_V = pk(1, 1, 0, 1, 1, 0, 0, 4'd6, 0, 0, 0);
    for (int i = 0; i < 16; i++) za[i] = 0;

    rst = 1'b1; bus_if.start_i = 1'b0; bus_if.data_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with noisy inputs, then idle with data_valid ignored.
    for (int i = 0; i < 2; i++)
      q.push_back('{rst: 1'b1, start: 1'b1, valid: 1'b1, exp: RST_V, eff: 1'b0, lat: 0});
    for (int i = 0; i < 3; i++) push(1'b0, rv(), RST_V);

    // Zero-wait message from IDLE, then randomized re-key from END.
    build_msg(1'b0, za, za, 3);
    rand_stalls();
    build_msg(1'b1, sa, sp, 2);

    // Five-cycle stall before the second PT block.
    sp = za; sp[1] = 5;
    build_msg(1'b1, za, sp, 2);

    // Reset in FIN at round 4, then a clean message from IDLE.
    rand_stalls();
    build_msg(1'b1, sa, sp, 0);
    while (q.size() > fin_idx + 5) void'(q.pop_back());
    q[fin_idx + 4].rst = 1'b1;
    push(1'b0, 1'b1, RST_V);
    push(1'b0, rv(), RST_V);
    rand_stalls();
    build_msg(1'b0, sa, sp, 2);

    for (int m = 0; m < 3; m++) begin
      rand_stalls();
      build_msg(1'b1, sa, sp, 1 + m);
    end

    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
